// File: rtl/pipeline_pkg.sv
// Shared pipeline types: data width, control-transfer encoding, redirect FSM states.
package pipeline_pkg;

  localparam int DATA_WIDTH = 32;

  // Control-transfer kind produced by decode and consumed by EX and the redirect block.
  typedef enum logic [2:0] {
    S_BR   = 3'd0,
    S_JAL  = 3'd1,
    S_JALR = 3'd2
  } specinst_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } redir_state_e;

endpackage

// File: rtl/branch_outcome.sv
// Combinational resolution of a control transfer: taken, actual next PC,
// mispredict against the front-end prediction and target misalignment.
module branch_outcome
  import pipeline_pkg::*;
(
  input  logic [2:0]            i_specinst,
  input  logic                  i_cond,
  input  logic [DATA_WIDTH-1:0] i_taken_tgt,
  input  logic [DATA_WIDTH-1:0] i_none_taken_tgt,
  input  logic [DATA_WIDTH-1:0] i_pred_pc,
  output logic                  o_valid_code,
  output logic                  o_taken,
  output logic [DATA_WIDTH-1:0] o_actual,
  output logic                  o_mispredict,
  output logic                  o_misaligned
);

  // Decode the transfer kind; unknown codes are not control transfers.
  always_comb begin
    o_valid_code = 1'b1;
    o_taken      = 1'b0;
    case (i_specinst)
      S_BR:         o_taken = i_cond;
      S_JAL, S_JALR: o_taken = 1'b1;
      default:      o_valid_code = 1'b0;
    endcase
  end

  assign o_actual     = o_taken ? i_taken_tgt : i_none_taken_tgt;
  assign o_mispredict = (o_actual != i_pred_pc);
  // Only a taken transfer can fault; the fall-through PC is always aligned.
  assign o_misaligned = o_taken && (o_actual[1:0] != 2'b00);

endmodule

// File: rtl/branch_redirect.sv
// Branch resolution back end: predictor update pulse, redirect request to IF
// with post-handshake squash window, and branch/mispredict performance counters.
//
//   state    | meaning
//   IDLE     | accepting resolved control transfers from EX
//   REDIRECT | holding redir_valid/redir_pc until IF accepts
//   DRAIN    | squashing younger stages for FLUSH_DEPTH cycles
module branch_redirect
  import pipeline_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  br_valid,
  output logic                  br_ready,
  input  logic [DATA_WIDTH-1:0] br_pc,
  input  logic [2:0]            br_specinst,
  input  logic                  br_cond,
  input  logic [DATA_WIDTH-1:0] br_taken_tgt,
  input  logic [DATA_WIDTH-1:0] br_none_taken_tgt,
  input  logic [DATA_WIDTH-1:0] br_pred_pc,
  output logic                  redir_valid,
  input  logic                  redir_ready,
  output logic [DATA_WIDTH-1:0] redir_pc,
  output logic                  flush,
  output logic                  upd_valid,
  output logic [DATA_WIDTH-1:0] upd_pc,
  output logic [DATA_WIDTH-1:0] upd_target,
  output logic                  upd_taken,
  output logic                  misalign,
  output logic [CNT_WIDTH-1:0]  perf_branches,
  output logic [CNT_WIDTH-1:0]  perf_mispredicts
);

  localparam int DCW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH + 1) : 1;

  redir_state_e          r_state;
  logic [DCW-1:0]        r_drain_cnt;
  logic                  r_redir_valid;
  logic [DATA_WIDTH-1:0] r_redir_pc;
  logic                  r_flush;
  logic                  r_upd_valid;
  logic [DATA_WIDTH-1:0] r_upd_pc;
  logic [DATA_WIDTH-1:0] r_upd_target;
  logic                  r_upd_taken;
  logic                  r_misalign;
  logic [CNT_WIDTH-1:0]  r_perf_branches;
  logic [CNT_WIDTH-1:0]  r_perf_mispredicts;

  logic                  w_valid_code;
  logic                  w_taken;
  logic [DATA_WIDTH-1:0] w_actual;
  logic                  w_mispredict;
  logic                  w_misaligned;

  branch_outcome u_outcome (
    .i_specinst       (br_specinst),
    .i_cond           (br_cond),
    .i_taken_tgt      (br_taken_tgt),
    .i_none_taken_tgt (br_none_taken_tgt),
    .i_pred_pc        (br_pred_pc),
    .o_valid_code     (w_valid_code),
    .o_taken          (w_taken),
    .o_actual         (w_actual),
    .o_mispredict     (w_mispredict),
    .o_misaligned     (w_misaligned)
  );

  // Ready is a pure state decode so EX never sees a combinational loop through us.
  assign br_ready = (r_state == IDLE);

  // Redirect FSM with registered outputs, drain down-counter and perf counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= IDLE;
      r_drain_cnt        <= '0;
      r_redir_valid      <= 1'b0;
      r_redir_pc         <= '0;
      r_flush            <= 1'b0;
      r_upd_valid        <= 1'b0;
      r_upd_pc           <= '0;
      r_upd_target       <= '0;
      r_upd_taken        <= 1'b0;
      r_misalign         <= 1'b0;
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else begin
      r_upd_valid <= 1'b0;
      r_misalign  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_flush       <= 1'b0;
          r_redir_valid <= 1'b0;
          if (br_valid && w_valid_code) begin
            r_perf_branches <= r_perf_branches + CNT_WIDTH'(1);
            r_upd_valid     <= 1'b1;
            r_upd_pc        <= br_pc;
            r_upd_target    <= w_actual;
            r_upd_taken     <= w_taken;
            // A misaligned target traps; the trap path handles refetch, not us.
            if (w_misaligned) begin
              r_misalign <= 1'b1;
              r_flush    <= 1'b1;
            end else if (w_mispredict) begin
              r_state            <= REDIRECT;
              r_redir_valid      <= 1'b1;
              r_redir_pc         <= w_actual;
              r_flush            <= 1'b1;
              r_perf_mispredicts <= r_perf_mispredicts + CNT_WIDTH'(1);
            end
          end
        end
        REDIRECT: begin
          if (redir_ready) begin
            r_redir_valid <= 1'b0;
            if (FLUSH_DEPTH == 0) begin
              r_state <= IDLE;
              r_flush <= 1'b0;
            end else begin
              r_state     <= DRAIN;
              r_drain_cnt <= DCW'(FLUSH_DEPTH);
            end
          end
        end
        DRAIN: begin
          if (r_drain_cnt <= DCW'(1)) begin
            r_state <= IDLE;
            r_flush <= 1'b0;
          end else begin
            r_drain_cnt <= r_drain_cnt - DCW'(1);
          end
        end
        default: begin
          r_state       <= IDLE;
          r_flush       <= 1'b0;
          r_redir_valid <= 1'b0;
        end
      endcase
    end
  end

  assign redir_valid      = r_redir_valid;
  assign redir_pc         = r_redir_pc;
  assign flush            = r_flush;
  assign upd_valid        = r_upd_valid;
  assign upd_pc           = r_upd_pc;
  assign upd_target       = r_upd_target;
  assign upd_taken        = r_upd_taken;
  assign misalign         = r_misalign;
  assign perf_branches    = r_perf_branches;
  assign perf_mispredicts = r_perf_mispredicts;

endmodule

// File: doc/branch_redirect.md
# branch_redirect

Back-end consumer of the resolved branch/jump targets produced in EX. Per accepted control-transfer instruction it selects the actual next PC, compares it with the PC the front end predicted, and:
- emits a one-cycle predictor-update pulse;
- on a mispredict, holds a redirect request to IF until accepted, then squashes the younger stages for a fixed number of cycles;
- counts branches and mispredicts.

It sits between the EX-stage target computation and the IF PC mux / predictor.

## Interface
Parameters:
- FLUSH_DEPTH, 2: cycles `flush` stays high after the redirect handshake (younger stages to drain).
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- br_valid  in  1  EX presents a resolved control-transfer instruction.
- br_ready  out  1  block can accept; equals (state == IDLE).
- br_pc  in  DATA_WIDTH  PC of the instruction.
- br_specinst  in  3  0 = S_BR, 1 = S_JAL, 2 = S_JALR; other codes mean "not a control transfer".
- br_cond  in  1  branch comparison result; only meaningful for S_BR.
- br_taken_tgt  in  DATA_WIDTH  taken target from EX.
- br_none_taken_tgt  in  DATA_WIDTH  br_pc + 4 from EX.
- br_pred_pc  in  DATA_WIDTH  next PC the front end fetched after this instruction.
- redir_valid  out  1  redirect request to IF.
- redir_ready  in  1  IF accepts the redirect.
- redir_pc  out  DATA_WIDTH  corrected fetch PC.
- flush  out  1  squash the IF/ID younger stages.
- upd_valid  out  1  one-cycle predictor update.
- upd_pc  out  DATA_WIDTH  PC being updated.
- upd_target  out  DATA_WIDTH  actual next PC.
- upd_taken  out  1  whether the transfer was taken.
- misalign  out  1  one-cycle pulse: taken target not 4-byte aligned (instruction-address-misaligned).
- perf_branches  out  CNT_WIDTH  accepted control transfers.
- perf_mispredicts  out  CNT_WIDTH  mispredicts, excluding misaligned cases.

## Operation
- **Fire:** br_valid && br_ready.
- **taken:** 1 for S_JAL and S_JALR; br_cond for S_BR.
- **actual:** taken ? br_taken_tgt : br_none_taken_tgt.
- **mispredict:** actual != br_pred_pc, compared over the full DATA_WIDTH bits.
- **Fire with a code other than 0/1/2:** accepted, no effect. No pulse, no counter change, no state change.
- **Fire with a valid code**, applied at the next edge:
  - perf_branches increments.
  - upd_valid pulses with upd_pc = br_pc, upd_target = actual, upd_taken = taken.
  - Then exactly one of the following, in priority order:
    - If taken && actual[1:0] != 0: pulse misalign and flush for one cycle; no redirect; state stays IDLE. The trap path owns recovery.
    - Else if mispredict: state goes to REDIRECT, redir_pc = actual, and perf_mispredicts increments.
    - Else: nothing further.
- **States:**
  - IDLE: waiting for a fire.
  - REDIRECT: redir_valid = 1; redir_pc is stable until the handshake.
  - DRAIN: down-counts FLUSH_DEPTH cycles.
- **Transitions:**
  - IDLE to REDIRECT on a mispredicting fire.
  - REDIRECT to DRAIN on redir_valid && redir_ready; the counter loads FLUSH_DEPTH.
  - DRAIN to IDLE when the counter reaches 1 at that edge.
  - FLUSH_DEPTH = 0 means REDIRECT goes straight to IDLE.
- **flush:** high in every REDIRECT and DRAIN cycle, plus the misalign cycle.
- **Counters:** wrap modulo 2^CNT_WIDTH.
- **Reset:**
  - All outputs go to 0, state to IDLE, counters to 0; upd_pc, upd_target and redir_pc go to 0.
  - A reset in REDIRECT or DRAIN abandons the redirect.
  - Reset wins over a simultaneous fire.

## Timing
- Every output except br_ready is registered. br_ready is decoded from the state register only, with no combinational path from any input.
- Fire at edge N:
  - upd_valid, misalign and the counter increments are visible in cycle N+1.
  - For a mispredict, redir_valid and flush rise in N+1 and br_ready falls in N+1.
- redir_valid, once high, stays high and redir_pc stays unchanged until redir_ready is sampled high. redir_ready may be high before redir_valid.
- Redirect handshake at edge M: redir_valid is low in M+1, flush stays high for cycles M+1 … M+FLUSH_DEPTH, and br_ready is high in M+FLUSH_DEPTH+1.
- Best-case mispredict-to-next-accept, with redir_ready tied high, is FLUSH_DEPTH + 2 cycles.
- Back-to-back correctly predicted fires are accepted every cycle; upd_valid is high on consecutive cycles.

## Structure
- pipeline_pkg gains:
  - the specinst encoding as a shared enum (S_BR = 0, S_JAL = 1, S_JALR = 2), which the EX target-compute block also uses;
  - the redirect state enum (IDLE, REDIRECT, DRAIN).
- DATA_WIDTH comes from pipeline_pkg.
- One combinational sub-module, branch_outcome, computes taken, actual, mispredict and misaligned. The top level holds the FSM, the drain counter, the output registers and the perf counters.

## Test plan
- **Predicted not-taken beq:** S_BR, br_cond = 0, br_pc = 0x1000, none_taken = 0x1004, pred = 0x1004. Expect upd_valid pulse (upd_taken = 0, upd_target = 0x1004), no redir_valid, perf_branches = 1, br_ready stays 1.
- **Mispredicted taken branch, redir_ready tied 1, FLUSH_DEPTH = 2:** S_BR, br_cond = 1, taken = 0x2000, pred = 0x1004. Expect redir_valid for 1 cycle with redir_pc = 0x2000, flush high for 3 cycles, br_ready low for 3 cycles, perf_mispredicts = 1.
- **Redirect stall:** JALR to 0x8000_0000, pred = 0x1004, redir_ready held 0 for 5 cycles. Expect redir_valid and redir_pc stable for 6 cycles and br_valid ignored throughout; after the handshake, drain completes as in the previous scenario.
- **Misaligned JAL:** taken = 0x1002. Expect misalign and flush pulsed for 1 cycle with no redir_valid, perf_branches incremented, perf_mispredicts unchanged.
- **Back-to-back and invalid code:** 4 correctly predicted fires on consecutive cycles, then one fire with specinst = 5. Expect 4 consecutive upd_valid cycles, perf_branches = 4, and nothing at all for the specinst = 5 fire.
- **Reset in DRAIN:** assert rst during DRAIN. Next cycle: every output is 0, br_ready = 1, counters are 0, and a new fire is accepted immediately.
